fwd_hazard_unit: RTL

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_hazard_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for a classic five-stage pipeline.
// Computes the per-source EX forwarding selects one stage early, in ID, and
// registers them. It also detects load-use hazards and inserts LU_BUBBLES
// bubbles per hazard. Branch/jump flush takes priority over hazards and over
// any stall already in progress.
module fwd_hazard_unit #(
    parameter int AW         = 5,
    parameter int NSRC       = 2,
    parameter int LU_BUBBLES = 1,
    parameter int CW         = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [NSRC*AW-1:0]   id_rs,
    input  logic [NSRC-1:0]      id_rs_used,
    input  logic [AW-1:0]        ex_rd,
    input  logic                 ex_regwrite,
    input  logic                 ex_memread,
    input  logic [AW-1:0]        mem_rd,
    input  logic                 mem_regwrite,
    input  logic                 flush,
    output logic [2*NSRC-1:0]    fwd_sel,
    output logic                 stall,
    output logic                 bubble,
    output logic [CW-1:0]        stall_cycles
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    // Forwarding select encodings as seen by the EX operand muxes.
    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b10;
    localparam logic [1:0] SEL_MEMWB = 2'b01;

    // The bubble counter holds the number of bubbles still owed after the
    // current one. The hazard-detect cycle itself is the first bubble.
    localparam logic [1:0] LU_LOAD  = 2'(LU_BUBBLES - 1);
    localparam logic [1:0] CNT_ZERO = 2'd0;
    localparam logic [1:0] CNT_ONE  = 2'd1;

    localparam logic [CW-1:0]     STALL_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0]     STALL_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]     STALL_ZERO = {CW{1'b0}};
    localparam logic [2*NSRC-1:0] SEL_ZERO   = {(2*NSRC){1'b0}};

    state_t              state_r;
    logic [1:0]          bub_cnt_r;
    logic                hazard_s;
    logic [2*NSRC-1:0]   fwd_next_s;

    // A producer can supply a source if it writes a non-x0 register that
    // matches the source address. Writes to x0 are discarded by the
    // register file, so they are never forwarded.
    function automatic logic producer_hit(
        input logic          wr_en,
        input logic [AW-1:0] rd,
        input logic [AW-1:0] rs
    );
        producer_hit = wr_en && (rd != {AW{1'b0}}) && (rd == rs);
    endfunction

    // Next-cycle forwarding selects and load-use hazard detection for the
    // instruction currently in ID. A WB-stage producer needs no select
    // because the register file writes before it is read.
    always_comb begin
        hazard_s   = 1'b0;
        fwd_next_s = SEL_ZERO;
        for (int i = 0; i < NSRC; i++) begin
            if (id_valid && id_rs_used[i]) begin
                if (producer_hit(ex_regwrite, ex_rd, id_rs[i*AW +: AW])) begin
                    fwd_next_s[2*i +: 2] = SEL_EXMEM;
                end else if (producer_hit(mem_regwrite, mem_rd, id_rs[i*AW +: AW])) begin
                    fwd_next_s[2*i +: 2] = SEL_MEMWB;
                end else begin
                    fwd_next_s[2*i +: 2] = SEL_RF;
                end
                if (ex_memread && producer_hit(ex_regwrite, ex_rd, id_rs[i*AW +: AW])) begin
                    hazard_s = 1'b1;
                end else begin
                    hazard_s = hazard_s;
                end
            end else begin
                fwd_next_s[2*i +: 2] = SEL_RF;
            end
        end
    end

    // Pipeline control. Flush kills ID/EX, so it bubbles but must not hold
    // the PC, because the redirect has to be taken.
    always_comb begin
        if (reset) begin
            stall  = 1'b0;
            bubble = 1'b0;
        end else if (flush) begin
            stall  = 1'b0;
            bubble = 1'b1;
        end else if (state_r == STALL) begin
            stall  = 1'b1;
            bubble = 1'b1;
        end else if (hazard_s) begin
            stall  = 1'b1;
            bubble = 1'b1;
        end else begin
            stall  = 1'b0;
            bubble = 1'b0;
        end
    end

    // Load-use stall sequencer. It leaves STALL on the edge where the last
    // owed bubble is consumed, so each hazard yields exactly LU_BUBBLES.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= RUN;
            bub_cnt_r <= CNT_ZERO;
        end else if (flush) begin
            state_r   <= RUN;
            bub_cnt_r <= CNT_ZERO;
        end else begin
            case (state_r)
                RUN: begin
                    if (hazard_s) begin
                        bub_cnt_r <= LU_LOAD;
                        state_r   <= (LU_BUBBLES > 1) ? STALL : RUN;
                    end else begin
                        bub_cnt_r <= CNT_ZERO;
                        state_r   <= RUN;
                    end
                end
                STALL: begin
                    if (bub_cnt_r <= CNT_ONE) begin
                        bub_cnt_r <= CNT_ZERO;
                        state_r   <= RUN;
                    end else begin
                        bub_cnt_r <= bub_cnt_r - CNT_ONE;
                        state_r   <= STALL;
                    end
                end
                default: begin
                    bub_cnt_r <= CNT_ZERO;
                    state_r   <= RUN;
                end
            endcase
        end
    end

    // Register the selects into EX. A bubble carries no operands, so it
    // always reads the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_sel <= SEL_ZERO;
        end else if (bubble) begin
            fwd_sel <= SEL_ZERO;
        end else begin
            fwd_sel <= fwd_next_s;
        end
    end

    // Performance counter of stalled cycles. It saturates rather than wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= STALL_ZERO;
        end else if (stall && (stall_cycles != STALL_MAX)) begin
            stall_cycles <= stall_cycles + STALL_ONE;
        end else begin
            stall_cycles <= stall_cycles;
        end
    end

endmodule
